// File: rtl/cam_frame_writer.sv
// cam_frame_writer: DVP camera bytes -> SDRAM write-FIFO beats, one wr_load per frame
// Ports: pclk, rst_n (async, active-low); sdram_init_done (clk_ref domain, synchronised here);
//   cam_vsync/cam_href/cam_data (DVP input); wrf_wrreq/wrf_din (write-FIFO beat);
//   wr_load (frame-start address reset); sdram_read_valid (sticky, first good frame stored);
//   frame_done/frame_err (frame close pulse and status); frame_cnt (good frames, wrapping).
module cam_frame_writer #(
  parameter int H_BYTES     = 1280,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10,
  parameter int LOAD_CYC    = 8,
  parameter int VS_POL      = 1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wrf_wrreq,
  output logic [7:0]  wrf_din,
  output logic        wr_load,
  output logic        sdram_read_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);
  localparam int CW = $clog2(H_BYTES + 1);
  localparam int RW = $clog2(V_LINES + 1);
  localparam int SW = SKIP_FRAMES > 0 ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int LW = $clog2(LOAD_CYC);
  localparam logic [CW-1:0] H_MAX = CW'(H_BYTES);
  localparam logic [RW-1:0] R_MAX = RW'(V_LINES);
  localparam logic [SW-1:0] S_END = SW'(SKIP_FRAMES);
  localparam logic [LW-1:0] L_END = LW'(LOAD_CYC - 1);
  typedef enum logic [1:0] {IDLE, SKIP, LOAD, CAPTURE} state_t;
  state_t state, state_n;
  logic init_s1, init_sync, vs_r1, vs_r2, href_r1, href_r2;
  logic [7:0] data_r1;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [SW-1:0] skip_cnt, skip_n;
  logic [LW-1:0] load_cnt, load_n;
  logic err, err_n, wrreq_n, wr_load_n, rv_n, done_n, ferr_n, close_err;
  logic [15:0] cnt_n;
  logic vs_in, vs_rise, href_fall;
  assign vs_in = VS_POL != 0 ? cam_vsync : ~cam_vsync;
  assign vs_rise = vs_r1 & ~vs_r2;
  assign href_fall = ~href_r1 & href_r2;
  always_comb begin
    state_n = state;
    skip_n = skip_cnt;
    load_n = load_cnt;
    col_n = col;
    row_n = row;
    err_n = err;
    wrreq_n = 1'b0;
    done_n = 1'b0;
    ferr_n = frame_err;
    cnt_n = frame_cnt;
    rv_n = sdram_read_valid;
    close_err = 1'b0;
    if (!init_sync) begin
      state_n = IDLE;
      skip_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SKIP;
          skip_n = '0;
        end
        SKIP: if (vs_rise) begin
          if (skip_cnt == S_END) begin
            state_n = LOAD;
            load_n = '0;
            col_n = '0;
            row_n = '0;
            err_n = 1'b0;
          end else skip_n = skip_cnt + 1'b1;
        end
        LOAD: begin
          // bytes arriving while the address is being reset are lost: mark the frame bad
          col_n = '0;
          row_n = '0;
          err_n = err | href_r1;
          load_n = load_cnt + 1'b1;
          state_n = load_cnt == L_END ? CAPTURE : LOAD;
        end
        CAPTURE: begin
          wrreq_n = href_r1 & (col < H_MAX) & (row < R_MAX);
          if (href_r1) begin
            if (col < H_MAX) col_n = col + 1'b1;
            else err_n = 1'b1;
            if (row == R_MAX) err_n = 1'b1;
          end
          if (href_fall) begin
            col_n = '0;
            if (row < R_MAX) row_n = row + 1'b1;
            if (col != H_MAX) err_n = 1'b1;
          end
          if (vs_rise) begin
            // a line still open at vsync (col_n != 0) is a truncated short line
            close_err = err_n | (row_n != R_MAX) | (col_n != '0);
            done_n = 1'b1;
            ferr_n = close_err;
            cnt_n = close_err ? frame_cnt : frame_cnt + 16'd1;
            rv_n = sdram_read_valid | ~close_err;
            state_n = LOAD;
            load_n = '0;
            col_n = '0;
            row_n = '0;
            err_n = 1'b0;
          end
        end
      endcase
    end
    wr_load_n = state_n == LOAD;
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {init_s1, init_sync, vs_r1, vs_r2, href_r1, href_r2} <= '0;
      data_r1 <= '0;
      col <= '0;
      row <= '0;
      skip_cnt <= '0;
      load_cnt <= '0;
      err <= 1'b0;
      wrf_wrreq <= 1'b0;
      wrf_din <= '0;
      wr_load <= 1'b0;
      sdram_read_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      init_s1 <= sdram_init_done;
      init_sync <= init_s1;
      vs_r1 <= vs_in;
      vs_r2 <= vs_r1;
      href_r1 <= cam_href;
      href_r2 <= href_r1;
      data_r1 <= cam_data;
      col <= col_n;
      row <= row_n;
      skip_cnt <= skip_n;
      load_cnt <= load_n;
      err <= err_n;
      wrf_wrreq <= wrreq_n;
      wrf_din <= data_r1;
      wr_load <= wr_load_n;
      sdram_read_valid <= rv_n;
      frame_done <= done_n;
      frame_err <= ferr_n;
      frame_cnt <= cnt_n;
    end
  end
endmodule
